// File: rtl/sram_resp_if.sv
// sram_resp_if: CPU sram-like port bundle (requester = master, memory = slave)
interface sram_resp_if;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        rdata_valid;
  logic        err;
  modport master (output sram_en, sram_wen, sram_addr, sram_wdata, input sram_rdata, rdata_valid, err);
  modport slave (input sram_en, sram_wen, sram_addr, sram_wdata, output sram_rdata, rdata_valid, err);
endinterface

// File: rtl/sram_resp_mem.sv
// sram_resp_mem: byte-writable word SRAM with LATENCY-stage read pipeline and window error flag; SRAM_RESP_STATS_EN adds rd_count/wr_count
module sram_resp_mem #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          LATENCY   = 1
) (
  input  logic        clk,
  input  logic        rst,
`ifdef SRAM_RESP_STATS_EN
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
`endif
  sram_resp_if.slave  sram
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH);
  if (LATENCY < 1 || LATENCY > 4) begin : g_lat_chk
    $error("sram_resp_mem: LATENCY must be 1..4");
  end
  logic [31:0]        r_mem [DEPTH];
  logic [LATENCY-1:0] r_vld;
  logic [LATENCY-1:0] r_err;
  logic [31:0]        r_dat [LATENCY];
  logic [31:0]        w_off;
  logic [AW-1:0]      w_idx;
  logic               w_hit;
  logic               w_rd;
  logic               w_wr;
  always_comb begin
    w_off = sram.sram_addr - BASE_ADDR;
    w_hit = w_off < SPAN;
    w_idx = w_off[AW+1:2];
    w_rd  = sram.sram_en && sram.sram_wen == 4'b0;
    w_wr  = sram.sram_en && sram.sram_wen != 4'b0;
  end
  always_ff @(posedge clk) begin
    if (!rst && w_wr && w_hit)
      for (int b = 0; b < 4; b++)
        if (sram.sram_wen[b]) r_mem[w_idx][8*b +: 8] <= sram.sram_wdata[8*b +: 8];
  end
  // data registers only load behind a valid read, so the last stage holds the last delivered word
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      r_err <= '0;
      for (int i = 0; i < LATENCY; i++) r_dat[i] <= '0;
    end else begin
      r_vld[0] <= w_rd;
      r_err[0] <= sram.sram_en && !w_hit;
      if (w_rd) r_dat[0] <= w_hit ? r_mem[w_idx] : 32'h0;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_err[i] <= r_err[i-1];
        if (r_vld[i-1]) r_dat[i] <= r_dat[i-1];
      end
    end
  end
  assign sram.sram_rdata  = r_dat[LATENCY-1];
  assign sram.rdata_valid = r_vld[LATENCY-1];
  assign sram.err         = r_err[LATENCY-1];
`ifdef SRAM_RESP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (r_vld[LATENCY-1] && !r_err[LATENCY-1] && rd_count != '1) rd_count <= rd_count + 32'd1;
      if (w_wr && w_hit && wr_count != '1) wr_count <= wr_count + 32'd1;
    end
  end
`endif
endmodule
